// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types for the Wishbone arbiter.
// Grant state encoding and master count.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } arb_state_t;

    localparam int ARB_NMASTERS = 2;

endpackage

// File: rtl/wb4.sv
// WB4: Wishbone B4 classic bundle.
// Master drives request fields, slave returns data and ack.
interface WB4 #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic clk
);
    logic [ADDR_W-1:0] ADR;
    logic [DATA_W-1:0] DAT_O;
    logic [DATA_W-1:0] DAT_I;
    logic              WE;
    logic              STB;
    logic              CYC;
    logic              ACK;

    modport master (
        input  clk,
        output ADR, DAT_O, WE, STB, CYC,
        input  DAT_I, ACK
    );

    modport slave (
        input  clk,
        input  ADR, DAT_O, WE, STB, CYC,
        output DAT_I, ACK
    );
endinterface

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin picker.
// On a tie the master that was not granted last wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    // pick a single requester, or alternate on a tie
    always_comb begin
        gnt_valid = |req;
        gnt_idx   = 1'b0;
        case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ~last;
            default: gnt_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: shares one Wishbone slave between two masters.
// Grant is held for the whole CYC; ties alternate round-robin.
module wb_arbiter2
    import wb_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RESET_PRIO = 0
) (
    input logic clk,
    input logic rst,
    WB4.slave   wb_m0,
    WB4.slave   wb_m1,
    WB4.master  wb_s
);

    // last starts as the loser so RESET_PRIO wins the first tie
    localparam logic LAST_RST = (RESET_PRIO == 0);

    arb_state_t state;
    arb_state_t state_nxt;
    logic       last;
    logic       pick_valid;
    logic       pick_idx;

    rr_pick2 u_pick (
        .req       ({wb_m1.CYC, wb_m0.CYC}),
        .last      (last),
        .gnt_valid (pick_valid),
        .gnt_idx   (pick_idx)
    );

    // grant state and last-owner registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            last  <= LAST_RST;
        end else begin
            state <= state_nxt;
            if (state_nxt == OWN0) last <= 1'b0;
            if (state_nxt == OWN1) last <= 1'b1;
        end
    end

    // next grant: hold while owner keeps CYC, hand off directly
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (pick_valid)
                    state_nxt = pick_idx ? OWN1 : OWN0;
            end
            OWN0: begin
                if (!wb_m0.CYC)
                    state_nxt = wb_m1.CYC ? OWN1 : IDLE;
            end
            OWN1: begin
                if (!wb_m1.CYC)
                    state_nxt = wb_m0.CYC ? OWN0 : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // route owner request to slave and slave ack to owner only
    always_comb begin
        wb_s.ADR   = {ADDR_W{1'b0}};
        wb_s.DAT_O = {DATA_W{1'b0}};
        wb_s.WE    = 1'b0;
        wb_s.STB   = 1'b0;
        wb_s.CYC   = 1'b0;
        wb_m0.ACK  = 1'b0;
        wb_m1.ACK  = 1'b0;
        unique case (state)
            OWN0: begin
                wb_s.ADR   = wb_m0.ADR;
                wb_s.DAT_O = wb_m0.DAT_O;
                wb_s.WE    = wb_m0.WE;
                wb_s.STB   = wb_m0.STB;
                wb_s.CYC   = wb_m0.CYC;
                wb_m0.ACK  = wb_s.ACK;
            end
            OWN1: begin
                wb_s.ADR   = wb_m1.ADR;
                wb_s.DAT_O = wb_m1.DAT_O;
                wb_s.WE    = wb_m1.WE;
                wb_s.STB   = wb_m1.STB;
                wb_s.CYC   = wb_m1.CYC;
                wb_m1.ACK  = wb_s.ACK;
            end
            default: ;
        endcase
    end

    // read data is broadcast; it only matters alongside ACK
    assign wb_m0.DAT_I = wb_s.DAT_I;
    assign wb_m1.DAT_I = wb_s.DAT_I;

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: directed and randomized checks of the arbiter.
// A RAM with registered ACK stands in for ram_wb.
module tb_wb_arbiter2;

    localparam int LAT_MAX = 12;

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        int unsigned t;
    } txn_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    WB4 #(.ADDR_W(32), .DATA_W(32)) m0_if (.clk(clk));
    WB4 #(.ADDR_W(32), .DATA_W(32)) m1_if (.clk(clk));
    WB4 #(.ADDR_W(32), .DATA_W(32)) s_if  (.clk(clk));

    logic [1:0]  cyc;
    logic [1:0]  stb;
    logic [1:0]  we;
    logic [31:0] adr  [2];
    logic [31:0] dato [2];
    logic [31:0] dati [2];
    logic [1:0]  ack;

    assign m0_if.CYC   = cyc[0];
    assign m0_if.STB   = stb[0];
    assign m0_if.WE    = we[0];
    assign m0_if.ADR   = adr[0];
    assign m0_if.DAT_O = dato[0];
    assign m1_if.CYC   = cyc[1];
    assign m1_if.STB   = stb[1];
    assign m1_if.WE    = we[1];
    assign m1_if.ADR   = adr[1];
    assign m1_if.DAT_O = dato[1];
    assign ack         = {m1_if.ACK, m0_if.ACK};
    assign dati[0]     = m0_if.DAT_I;
    assign dati[1]     = m1_if.DAT_I;

    wb_arbiter2 #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .RESET_PRIO (0)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .wb_m0 (m0_if),
        .wb_m1 (m1_if),
        .wb_s  (s_if)
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'hDEAD_BEEF : (32'h5A00_0000 | i);
    endfunction

    // RAM: one registered ACK per request, then a bubble
    logic [31:0] ram [64];
    logic        ram_ack;
    logic [31:0] ram_dat;
    logic        loaded = 1'b0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_ack <= 1'b0;
            if (!loaded) begin
                for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
                loaded <= 1'b1;
            end
        end else begin
            ram_ack <= 1'b0;
            if (s_if.CYC && s_if.STB && !ram_ack) begin
                ram_ack <= 1'b1;
                ram_dat <= ram[s_if.ADR[7:2]];
                if (s_if.WE) ram[s_if.ADR[7:2]] <= s_if.DAT_O;
            end
        end
    end
    assign s_if.ACK   = ram_ack;
    assign s_if.DAT_I = ram_dat;

    int unsigned cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    logic [31:0] ref_mem [64];
    txn_t        q0 [$];
    txn_t        q1 [$];
    bit          sb_on = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int id, input bit w, input logic [31:0] a,
                         input logic [31:0] d);
        cyc[id]  = 1'b1;
        stb[id]  = 1'b1;
        we[id]   = w;
        adr[id]  = a;
        dato[id] = d;
    endtask

    task automatic release_m(input int id);
        cyc[id] = 1'b0;
        stb[id] = 1'b0;
        we[id]  = 1'b0;
    endtask

    task automatic wait_ack(input int id);
        int t = 0;
        do begin
            step();
            t++;
        end while (!ack[id] && t < 20);
        check($sformatf("ack_seen_m%0d", id), {31'b0, ack[id]}, 1);
    endtask

    // scoreboard: pop the issued beat whenever a master sees ACK
    task automatic monitor();
        txn_t tx;
        forever begin
            @(negedge clk);
            if (sb_on) begin
                if (ack[0] && ack[1]) begin
                    checks++;
                    errors++;
                    $display("FAIL dual_ack actual=11 required=not both");
                end
                for (int i = 0; i < 2; i++) begin
                    if (ack[i]) begin
                        if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL spurious_ack m%0d actual=1 required=0", i);
                        end else begin
                            tx = (i == 0) ? q0.pop_front() : q1.pop_front();
                            if (tx.w) ref_mem[tx.a[7:2]] = tx.d;
                            else check($sformatf("rd_data_m%0d", i), dati[i],
                                       ref_mem[tx.a[7:2]]);
                            check($sformatf("wait_bound_m%0d", i),
                                  {31'b0, (cyc_cnt - tx.t) <= LAT_MAX}, 1);
                        end
                    end
                end
            end
        end
    endtask

    // random master: bursts of 1..4 beats under one CYC
    task automatic master(input int id, input int nburst);
        int   len;
        int   t;
        bit   w;
        logic [31:0] a;
        logic [31:0] d;
        for (int b = 0; b < nburst; b++) begin
            repeat ($urandom_range(0, 3)) step();
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) begin
                w = 1'($urandom_range(0, 1));
                a = 32'($urandom_range(0, 15)) << 2;
                d = $urandom;
                drive(id, w, a, d);
                if (id == 0) q0.push_back('{w, a, d, cyc_cnt});
                else         q1.push_back('{w, a, d, cyc_cnt});
                t = 0;
                do begin
                    step();
                    t++;
                end while (!ack[id] && t < 200);
                if (!ack[id]) begin
                    checks++;
                    errors++;
                    $display("FAIL timeout_m%0d actual=no_ack required=ack", id);
                    if (id == 0) void'(q0.pop_front());
                    else         void'(q1.pop_front());
                end
            end
            release_m(id);
            step();
        end
    endtask

    initial begin
        logic leak;
        rst  = 1'b1;
        cyc  = '0;
        stb  = '0;
        we   = '0;
        adr  = '{32'h0, 32'h0};
        dato = '{32'h0, 32'h0};
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        fork
            monitor();
        join_none

        repeat (3) step();
        check("rst_s_cyc", {31'b0, s_if.CYC}, 0);
        check("rst_s_stb", {31'b0, s_if.STB}, 0);
        check("rst_s_adr", s_if.ADR, 0);
        check("rst_acks", {30'b0, ack}, 0);
        rst = 1'b0;
        step();

        // single uncontended read
        drive(0, 1'b0, 32'h10, 32'h0);
        #1 check("single_n_cyc", {31'b0, s_if.CYC}, 0);
        step();
        check("single_n1_cyc", {31'b0, s_if.CYC}, 1);
        check("single_n1_adr", s_if.ADR, 32'h10);
        check("single_n1_ack", {31'b0, ack[0]}, 0);
        step();
        check("single_n2_ack", {31'b0, ack[0]}, 1);
        check("single_n2_dat", dati[0], 32'hDEAD_BEEF);
        check("single_m1_ack", {31'b0, ack[1]}, 0);
        release_m(0);
        step();

        // reset while m1 owns the bus
        drive(1, 1'b0, 32'h18, 32'h0);
        step();
        step();
        check("m1_owns_adr", s_if.ADR, 32'h18);
        #2 rst = 1'b1;
        #1;
        check("midrst_s_cyc", {31'b0, s_if.CYC}, 0);
        check("midrst_s_stb", {31'b0, s_if.STB}, 0);
        check("midrst_acks", {30'b0, ack}, 0);
        release_m(1);
        step();
        rst = 1'b0;
        step();
        check("postrst_idle", {31'b0, s_if.CYC}, 0);

        // tie after reset: m0 first, then direct handoff, no stale ack
        drive(0, 1'b0, 32'h10, 32'h0);
        drive(1, 1'b0, 32'h14, 32'h0);
        step();
        check("tie_rst_m0", s_if.ADR, 32'h10);
        step();
        check("tie_m0_ack", {31'b0, ack[0]}, 1);
        check("tie_m1_wait", {31'b0, ack[1]}, 0);
        release_m(0);
        #1 check("handoff_gap", {31'b0, s_if.CYC}, 0);
        step();
        check("handoff_adr", s_if.ADR, 32'h14);
        check("stale_ack", {31'b0, ack[1]}, 0);
        step();
        check("handoff_ack", {31'b0, ack[1]}, 1);
        check("handoff_dat", dati[1], ref_mem[5]);
        release_m(1);
        step();

        // m1 was last: next tie goes to m0
        drive(0, 1'b0, 32'h10, 32'h0);
        drive(1, 1'b0, 32'h14, 32'h0);
        step();
        check("tie_after_m1", s_if.ADR, 32'h10);
        wait_ack(0);
        release_m(0);
        wait_ack(1);
        release_m(1);
        step();

        // m0 was last: next tie goes to m1
        drive(0, 1'b0, 32'h10, 32'h0);
        wait_ack(0);
        release_m(0);
        step();
        drive(0, 1'b0, 32'h10, 32'h0);
        drive(1, 1'b0, 32'h14, 32'h0);
        step();
        check("tie_after_m0", s_if.ADR, 32'h14);
        wait_ack(1);
        release_m(1);
        wait_ack(0);
        release_m(0);
        step();

        // atomic 4-beat write burst from m1 while m0 waits
        leak = 1'b0;
        drive(1, 1'b1, 32'h20, 32'd1);
        step();
        drive(0, 1'b0, 32'h30, 32'h0);
        for (int k = 0; k < 4; k++) begin
            int t = 0;
            while (!ack[1] && t < 20) begin
                step();
                t++;
                leak |= ack[0];
            end
            ref_mem[8 + k] = 32'(k + 1);
            if (k < 3) drive(1, 1'b1, 32'h20 + 32'(4 * (k + 1)), 32'(k + 2));
            else       release_m(1);
            step();
            leak |= ack[0];
        end
        check("atomic_no_ack_m0", {31'b0, leak}, 0);
        wait_ack(0);
        check("atomic_m0_dat", dati[0], ref_mem[12]);
        release_m(0);
        step();
        for (int k = 0; k < 4; k++) begin
            drive(0, 1'b0, 32'h20 + 32'(4 * k), 32'h0);
            wait_ack(0);
            check($sformatf("readback_%0d", k), dati[0], 32'(k + 1));
        end
        release_m(0);
        step();

        // random soak against the scoreboard
        sb_on = 1'b1;
        fork
            master(0, 800);
            master(1, 800);
        join
        repeat (4) step();
        sb_on = 1'b0;
        check("lost_m0", q0.size(), 0);
        check("lost_m1", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
